// File: rtl/pipeline_fifo.sv
// Registered circular-buffer FIFO between two valid/backpressure stages.
// Output is registered, so din has no combinational path to dout.
module pipeline_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [Width-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_bp,
  output logic [Width-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_bp,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  // Full refuses a push even when popping the same cycle, keeping
  // din_bp free of any dependence on the downstream stage.
  assign w_full     = (r_count == CW'(Depth));
  assign din_bp     = !resetn || w_full;
  assign dout_valid = resetn && (r_count != '0);
  assign dout       = r_mem[r_rptr];
  assign count      = r_count;

  assign w_push = din_valid && !din_bp;
  assign w_pop  = dout_valid && !dout_bp;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_fifo.sv
// Bench for pipeline_fifo: directed vector table, streaming sequence,
// and random traffic checked against a queue-based reference.
module tb_pipeline_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_bp;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_bp = 1'b0;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];

  pipeline_fifo #(.Width(W), .Depth(D)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_bp     (din_bp),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_bp    (dout_bp),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rn;
    bit       dv;
    bit [7:0] d;
    bit       bp;
    bit       e_bp;
    bit       e_v;
    bit [7:0] e_d;
    int       e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rn, input bit dv, input bit [7:0] d,
                       input bit bp);
    @(negedge clk);
    resetn    = rn;
    din_valid = dv;
    din       = d;
    dout_bp   = bp;
    #1;
  endtask

  // Reference: occupancy is the queue length, head is the front entry.
  task automatic model_step(input string tag);
    bit e_bp;
    bit e_v;
    e_bp = !resetn || (q.size() == D);
    e_v  = resetn && (q.size() != 0);
    chk({tag, ".din_bp"}, 32'(din_bp), 32'(e_bp));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_v));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    if (e_v) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
    @(posedge clk);
    if (!resetn) begin
      q.delete();
    end else begin
      if (e_v && !dout_bp) void'(q.pop_front());
      if (din_valid && !e_bp) q.push_back(int'(din));
    end
  endtask

  initial begin
    // full / drain / push-while-full-pop / mid-operation reset
    tbl.push_back('{1,1,8'h11,1, 0,0,8'h00,0});
    tbl.push_back('{1,1,8'h22,1, 0,1,8'h11,1});
    tbl.push_back('{1,1,8'h33,1, 0,1,8'h11,2});
    tbl.push_back('{1,1,8'h44,1, 0,1,8'h11,3});
    tbl.push_back('{1,1,8'h55,1, 1,1,8'h11,4});
    tbl.push_back('{1,1,8'h55,1, 1,1,8'h11,4});
    tbl.push_back('{1,0,8'h00,0, 1,1,8'h11,4});
    tbl.push_back('{1,0,8'h00,0, 0,1,8'h22,3});
    tbl.push_back('{1,0,8'h00,0, 0,1,8'h33,2});
    tbl.push_back('{1,0,8'h00,0, 0,1,8'h44,1});
    tbl.push_back('{1,0,8'h00,0, 0,0,8'h00,0});
    tbl.push_back('{1,1,8'h9F,1, 0,0,8'h00,0});
    tbl.push_back('{1,1,8'hA0,1, 0,1,8'h9F,1});
    tbl.push_back('{1,1,8'hA1,1, 0,1,8'h9F,2});
    tbl.push_back('{1,1,8'hA2,1, 0,1,8'h9F,3});
    tbl.push_back('{1,1,8'hEE,0, 1,1,8'h9F,4});
    tbl.push_back('{1,0,8'h00,1, 0,1,8'hA0,3});
    tbl.push_back('{0,1,8'h77,0, 1,0,8'h00,3});
    tbl.push_back('{1,1,8'hB0,0, 0,0,8'h00,0});
    tbl.push_back('{1,0,8'h00,0, 0,1,8'hB0,1});
    tbl.push_back('{1,0,8'h00,0, 0,0,8'h00,0});

    drive(0, 1, 8'h99, 1);
    chk("rst.din_bp", 32'(din_bp), 32'd1);
    chk("rst.dout_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(tbl[i].rn, tbl[i].dv, tbl[i].d, tbl[i].bp);
      chk({nm, ".din_bp"}, 32'(din_bp), 32'(tbl[i].e_bp));
      chk({nm, ".dout_valid"}, 32'(dout_valid), 32'(tbl[i].e_v));
      chk({nm, ".count"}, 32'(count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_v) chk({nm, ".dout"}, 32'(dout), 32'(tbl[i].e_d));
      @(posedge clk);
    end

    // streaming: one-cycle latency, occupancy stays at 1, pointers wrap
    drive(0, 0, 8'h00, 0);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 8'(i), 0);
      chk("stream.din_bp", 32'(din_bp), 32'd0);
      chk("stream.count", 32'(count), (i == 0) ? 32'd0 : 32'd1);
      chk("stream.dout_valid", 32'(dout_valid), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("stream.dout", 32'(dout), 32'(i - 1));
      @(posedge clk);
    end
    drive(1, 0, 8'h00, 0);
    chk("stream.last", 32'(dout), 32'd19);
    chk("stream.lastcnt", 32'(count), 32'd1);
    @(posedge clk);
    drive(1, 0, 8'h00, 0);
    chk("stream.empty", 32'(dout_valid), 32'd0);
    chk("stream.emptycnt", 32'(count), 32'd0);
    @(posedge clk);

    // random traffic against the queue reference
    drive(0, 0, 8'h00, 0);
    @(posedge clk);
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      int pv;
      int pb;
      pv = (c / 1000) % 4;
      pb = (c / 1500) % 3;
      drive($urandom_range(0, 299) != 0,
            $urandom_range(0, 3) <= pv,
            8'($urandom),
            $urandom_range(0, 2) < pb);
      model_step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_fifo.md
PIPELINE_FIFO -- requirements
Module: pipeline_fifo

Interface
REQ-001 Parameter: Width, default 8, meaning payload bit width (>=1).
REQ-002 Parameter: Depth, default 4, meaning storage entries (power of two, >=2).
REQ-003 Port: clk  input  1  sole clock, all state updates on posedge.
REQ-004 Port: resetn  input  1  synchronous, active-low reset.
REQ-005 Port: din  input  Width  upstream payload.
REQ-006 Port: din_valid  input  1  upstream payload valid.
REQ-007 Port: din_bp  output  1  backpressure to upstream (1 = not accepting).
REQ-008 Port: dout  output  Width  payload to downstream (e.g. a fork input).
REQ-009 Port: dout_valid  output  1  downstream payload valid.
REQ-010 Port: dout_bp  input  1  backpressure from downstream.
REQ-011 Port: count  output  clog2(Depth+1)  current occupancy, 0..Depth.

Function
REQ-012 Push SHALL occur on a posedge where din_valid=1 and din_bp=0; pop SHALL occur on a posedge where dout_valid=1 and dout_bp=0.
REQ-013 Storage SHALL be a circular buffer with write and read pointers of clog2(Depth) bits that wrap from Depth-1 to 0.
REQ-014 din_bp SHALL be 1 when count==Depth or resetn==0, otherwise 0.
REQ-015 din_bp SHALL NOT depend combinationally on dout_bp or dout_valid; a full FIFO refuses a push even in a cycle where it pops.
REQ-016 dout_valid SHALL be 1 when count!=0 and resetn==1, otherwise 0.
REQ-017 dout SHALL equal the entry at the read pointer; its value is don't-care while dout_valid=0.
REQ-018 Latency SHALL be one cycle: data pushed on edge N appears on dout with dout_valid=1 after edge N at the earliest; no combinational path exists from din to dout.
REQ-019 While dout_valid=1 and dout_bp=1, dout SHALL remain stable across cycles.
REQ-020 Order SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-021 count update per edge: push only +1, pop only -1, push and pop together unchanged, neither unchanged.
REQ-022 Simultaneous push and pop with count==1 SHALL leave the new entry at the head next cycle and dout_valid=1 continuous.
REQ-023 Simultaneous push and pop with 1<count<Depth SHALL be permitted and SHALL preserve order across pointer wrap.
REQ-024 Pop on empty and push on full SHALL be impossible by construction (gated by REQ-014/REQ-016), never by relying on the neighbouring stage.
REQ-025 din_valid and dout_bp values while resetn=0 SHALL have no effect on state.

Reset
REQ-026 On a posedge with resetn=0, write pointer, read pointer and count SHALL be set to 0; storage contents need not be cleared.
REQ-027 While resetn=0, outputs SHALL be din_bp=1, dout_valid=0, count=0 on the first cycle after the reset edge, with din_bp and dout_valid forced combinationally from resetn.
REQ-028 Reset asserted mid-operation SHALL discard all held entries; the first cycle after resetn returns to 1 SHALL show din_bp=0, dout_valid=0, count=0.

Verification
REQ-029 Depth=4, dout_bp=1, push 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; din_bp=1 after the 4th push; a 5th value 0x55 is not accepted; dout=0x11 stable throughout.
REQ-030 From full, dout_bp=0 for 4 cycles with din_valid=0 -> dout sequence 0x11,0x22,0x33,0x44, then dout_valid=0, count=0, din_bp=0.
REQ-031 Continuous push and pop (din_valid=1, dout_bp=0) of 0..19 -> output 0..19 in order, one cycle after each push, count never exceeds 1, pointers wrap 5 times.
REQ-032 count=4, din_valid=1, dout_bp=0 in the same cycle -> pop occurs, push refused (din_bp=1), count=3 next cycle.
REQ-033 count=3 holding 0xA0,0xA1,0xA2, resetn=0 for one cycle with din_valid=1 -> din_bp=1 and dout_valid=0 during reset, count=0 after; next push 0xB0 appears as the first dout.
REQ-034 Random valid and backpressure for 10k cycles against a scoreboard -> no loss, duplication or reordering; count equals pushes minus pops; dout stable under dout_bp.
